negate_arbiter: RTL and testbench
=================================

// Module: negate_arbiter
// PURPOSE
//  Shares one WIDTH-bit two's-complement negation unit (B = ~A + 1) among N_REQ requesters.
//  Round-robin arbitration; one registered result slot with valid/ready handshake on each side.
//  Sits between ALU operand sources and the ALU result path; one negation issued per cycle max.
// PARAMETERS
//  N_REQ   4  number of requesters (2..8)
//  WIDTH   8  operand/result width in bits
// PORTS
//  clk        in   1             single clock, rising edge
//  rst        in   1             asynchronous, active-high reset
//  req_valid  in   N_REQ         requester i has operand on req_data slice i
//  req_data   in   N_REQ*WIDTH   operand of requester i at [i*WIDTH +: WIDTH]
//  req_ready  out  N_REQ         one-hot (or zero): requester i's operand accepted this cycle
//  rsp_valid  out  1             result slot holds a valid result
//  rsp_data   out  WIDTH         negated operand, ~A + 1 mod 2^WIDTH
//  rsp_id     out  clog2(N_REQ)  index of requester that owns rsp_data
//  rsp_ready  in   1             consumer takes the result this cycle when rsp_valid=1
//  busy       out  1             = rsp_valid | (|req_valid)
// BEHAVIOUR
//  - Clock/reset: one clock; reset is asynchronous and active-high.
//  - Reset: rsp_valid=0, rsp_data=0, rsp_id=0, rr pointer=0, state=EMPTY; req_ready=0 while rst=1.
//  - can_accept = !rsp_valid | rsp_ready (slot empty or drained this same cycle).
//  - Grant: combinational; first i with req_valid[i]=1 scanning ptr, ptr+1, ... wrapping mod N_REQ.
//  - req_ready[i] = grant[i] & can_accept & !rst; at most one bit high per cycle.
//  - Accept (req_valid[i] & req_ready[i]) on edge t: rsp_data<=~req_data[i]+1, rsp_id<=i,
//    rsp_valid=1 from t+1; latency exactly 1 cycle; ptr <= (i+1) mod N_REQ.
//  - No accept: ptr unchanged; rsp_valid cleared on rsp_ready, else result held stable.
//  - FSM (2 states): EMPTY -accept-> FULL; FULL -rsp_ready & !accept-> EMPTY;
//    FULL -rsp_ready & accept-> FULL (back-to-back, full throughput); FULL -!rsp_ready-> FULL.
//  - Backpressure: while FULL & !rsp_ready, req_ready=0, rsp_data/rsp_id must not change.
//  - Requester may drop req_valid without handshake; arbiter never latches without req_ready.
//  - Arithmetic: result truncated to WIDTH; 0 -> 0; most-negative (8'h80) -> 8'h80 (wraps).
//  - Wrap: ptr after granting N_REQ-1 becomes 0.
//  - Reset mid-operation: held result discarded, rsp_valid drops asynchronously.
// CONFIGURATION
//  NEGATE_ARB_OVF_FLAG_EN defined: extra output rsp_ovf (1 bit), registered with rsp_data;
//    rsp_ovf=1 iff accepted operand = 1 followed by WIDTH-1 zeros; reset 0; held under backpressure.
//  Undefined: port rsp_ovf absent; no other behaviour change.
// STRUCTURE
//  Package negate_arb_pkg: state enum {ST_EMPTY, ST_FULL}; function id_width(n)=clog2(n)
//    (min 1); constant default WIDTH=8.
//  Sub-module rr_arbiter (N_REQ; req, ptr -> one-hot grant, grant_idx, any): pure comb.
//  Top: rr_arbiter, can_accept logic, ptr register, result slot + FSM, negation (~A + 1).
// TESTING
//  1 Reset: assert rst mid-FULL -> rsp_valid=0, rsp_data=0, rsp_id=0, req_ready=0 same cycle.
//  2 Single: req_valid=4'b0010, data1=8'h05, rsp_ready=1 -> next cycle rsp_valid=1,
//    rsp_data=8'hFB, rsp_id=1.
//  3 Round-robin: req_valid=4'b1111 held, rsp_ready=1 -> rsp_id 0,1,2,3,0 on consecutive cycles.
//  4 Backpressure: FULL with 8'h10->8'hF0, rsp_ready=0 for 3 cycles -> req_ready=0,
//    rsp_data held 8'hF0; rsp_ready=1 -> next queued result follows next cycle.
//  5 Boundaries: operands 8'h00->8'h00, 8'h01->8'hFF, 8'h80->8'h80 (rsp_ovf=1 when
//    NEGATE_ARB_OVF_FLAG_EN defined), 8'h7F->8'h81.
//  6 Fairness wrap: after grant to 3, req_valid=4'b1001 -> grant 0 next, then 3.

Source files
------------

// File: rtl/negate_arb_pkg.sv
// Shared types and helpers for the negate_arbiter block.
// Optional feature macro used by the top: NEGATE_ARB_OVF_FLAG_EN.
package negate_arb_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  // Index width for n requesters; never narrower than one bit.
  function automatic int id_width(input int n);
    int w;
    w = $clog2(n);
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/negate_arbiter_rr_arbiter.sv
// Combinational round-robin picker: the first active request at or after i_ptr,
// wrapping modulo N_REQ, reported as a one-hot grant plus its index.
module rr_arbiter
  import negate_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int PTR_W = id_width(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N_REQ-1:0] o_grant,
  output logic [PTR_W-1:0] o_grantIdx,
  output logic             o_any
);

  int w_bestIdx;
  int w_bestDist;
  int w_dist;

  // Rotational distance from the pointer; the smallest distance among active requests wins.
  always_comb begin
    w_bestIdx  = 0;
    w_bestDist = N_REQ;
    w_dist     = 0;
    for (int i = 0; i < N_REQ; i++) begin
      w_dist = (i + N_REQ - int'(i_ptr)) % N_REQ;
      if (i_req[i] && (w_dist < w_bestDist)) begin
        w_bestDist = w_dist;
        w_bestIdx  = i;
      end
    end
  end

  assign o_any      = |i_req;
  assign o_grantIdx = PTR_W'(w_bestIdx);

  always_comb begin
    o_grant = '0;
    for (int i = 0; i < N_REQ; i++) begin
      o_grant[i] = o_any && (w_bestIdx == i);
    end
  end

endmodule

// File: rtl/negate_arbiter.sv
// Shared two's-complement negation unit with round-robin arbitration and a one-deep result slot.
// Define NEGATE_ARB_OVF_FLAG_EN to add the rsp_ovf most-negative-operand flag output.
module negate_arbiter
  import negate_arb_pkg::*;
#(
  parameter  int N_REQ = 4,
  parameter  int WIDTH = DEFAULT_WIDTH,
  localparam int ID_W  = id_width(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   rsp_valid,
  output logic [WIDTH-1:0]       rsp_data,
  output logic [ID_W-1:0]        rsp_id,
  input  logic                   rsp_ready,
  output logic                   busy
`ifdef NEGATE_ARB_OVF_FLAG_EN
  ,
  output logic                   rsp_ovf
`endif
);

  state_t           r_state;
  logic             r_rspValid;
  logic [WIDTH-1:0] r_rspData;
  logic [ID_W-1:0]  r_rspId;
  logic [ID_W-1:0]  r_ptr;

  logic [N_REQ-1:0] w_grant;
  logic [ID_W-1:0]  w_grantIdx;
  logic             w_any;
  logic             w_canAccept;
  logic             w_accept;
  logic [WIDTH-1:0] w_operand;
  logic [WIDTH-1:0] w_negated;
  logic [ID_W-1:0]  w_nextPtr;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .PTR_W (ID_W)
  ) u_rrArbiter (
    .i_req      (req_valid),
    .i_ptr      (r_ptr),
    .o_grant    (w_grant),
    .o_grantIdx (w_grantIdx),
    .o_any      (w_any)
  );

  // The slot can take a new result if it is empty or being drained this same cycle.
  assign w_canAccept = (r_state == ST_EMPTY) || rsp_ready;
  assign w_accept    = w_any && w_canAccept && !rst;
  assign req_ready   = w_grant & {N_REQ{w_canAccept && !rst}};

  always_comb begin
    w_operand = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_grant[i]) w_operand = req_data[i*WIDTH +: WIDTH];
    end
  end

  assign w_negated = ~w_operand + WIDTH'(1);
  assign w_nextPtr = (w_grantIdx == ID_W'(N_REQ - 1)) ? '0 : w_grantIdx + ID_W'(1);

  // Slot FSM: data/id load on every accept, so FULL->FULL gives back-to-back throughput.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_EMPTY;
      r_rspValid <= 1'b0;
      r_rspData  <= '0;
      r_rspId    <= '0;
      r_ptr      <= '0;
    end else begin
      if (w_accept) begin
        r_rspData <= w_negated;
        r_rspId   <= w_grantIdx;
        r_ptr     <= w_nextPtr;
      end
      unique case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            r_state    <= ST_FULL;
            r_rspValid <= 1'b1;
          end
        end
        ST_FULL: begin
          if (!w_accept && rsp_ready) begin
            r_state    <= ST_EMPTY;
            r_rspValid <= 1'b0;
          end
        end
        default: begin
          r_state    <= ST_EMPTY;
          r_rspValid <= 1'b0;
        end
      endcase
    end
  end

`ifdef NEGATE_ARB_OVF_FLAG_EN
  logic r_ovf;

  // Only the most-negative value negates to itself, which is the overflow case.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (w_accept) begin
      r_ovf <= (w_operand == {1'b1, {(WIDTH-1){1'b0}}});
    end
  end

  assign rsp_ovf = r_ovf;
`endif

  assign rsp_valid = r_rspValid;
  assign rsp_data  = r_rspData;
  assign rsp_id    = r_rspId;
  assign busy      = r_rspValid || (|req_valid);

endmodule

// File: tb/tb_negate_arbiter.sv
// Self-checking bench for negate_arbiter: directed scenarios plus a randomized run
// against a behavioural model (rotation scan + modular arithmetic negation).
module tb_negate_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0]   req_ready;
  logic           rsp_valid;
  logic [W-1:0]   rsp_data;
  logic [1:0]     rsp_id;
  logic           rsp_ready = 1'b0;
  logic           busy;
`ifdef NEGATE_ARB_OVF_FLAG_EN
  logic           rsp_ovf;
`endif

  int assertCount = 0;
  int failCount = 0;

  always #5 clk = ~clk;

  negate_arbiter #(
    .N_REQ (N),
    .WIDTH (W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .rsp_ready (rsp_ready),
    .busy      (busy)
`ifdef NEGATE_ARB_OVF_FLAG_EN
    ,
    .rsp_ovf   (rsp_ovf)
`endif
  );

   // Reference negation: 2^W - a, reduced modulo 2^W.
   function automatic logic [W-1:0] refNeg(input logic [W-1:0] a);
      int r;
      r = ((1 << W) - int'(a)) % (1 << W);
      return r[W-1:0];
   endfunction

   // Reference grant: walk ptr, ptr+1, ... modulo N, return first requester or -1.
   function automatic int pickReq(input logic [N-1:0] v, input int p);
      for (int k = 0; k < N; k++) begin
         int j;
         j = (p + k) % N;
         if (v[j]) return j;
      end
      return -1;
   endfunction

   // Pulse reset and leave the bench at a falling edge with reset released.
   task automatic doReset();
      rst = 1'b1;
      req_valid = '0;
      req_data = '0;
      rsp_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Reset values, then a held result wiped asynchronously by reset mid-cycle.
   task automatic test_reset();
      rst = 1'b1;
      req_valid = 4'b1111;
      #1;
      assertCount++;
      if (req_ready !== 4'b0000) begin failCount++; $display("[TB] FAIL reset_req_ready: got %b expected %b", req_ready, 4'b0000); end
      assertCount++;
      if (rsp_valid !== 1'b0) begin failCount++; $display("[TB] FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
      assertCount++;
      if (rsp_data !== 8'h00) begin failCount++; $display("[TB] FAIL reset_rsp_data: got %h expected 00", rsp_data); end
      assertCount++;
      if (rsp_id !== 2'd0) begin failCount++; $display("[TB] FAIL reset_rsp_id: got %0d expected 0", rsp_id); end
      @(negedge clk);
      rst = 1'b0;
      req_valid = 4'b0001;
      req_data = '0;
      req_data[7:0] = 8'h22;
      rsp_ready = 1'b0;
      @(negedge clk);
      #1;
      assertCount++;
      if (rsp_valid !== 1'b1 || rsp_data !== 8'hDE) begin failCount++; $display("[TB] FAIL prereset_full: got v=%b d=%h expected v=1 d=DE", rsp_valid, rsp_data); end
      req_valid = 4'b1111;
      #1;
      rst = 1'b1;
      #1;
      assertCount++;
      if (rsp_valid !== 1'b0 || rsp_data !== 8'h00 || rsp_id !== 2'd0) begin
         failCount++;
         $display("[TB] FAIL midreset_slot: got v=%b d=%h id=%0d expected v=0 d=00 id=0", rsp_valid, rsp_data, rsp_id);
      end
      assertCount++;
      if (req_ready !== 4'b0000) begin failCount++; $display("[TB] FAIL midreset_req_ready: got %b expected 0000", req_ready); end
      req_valid = '0;
   endtask

   task automatic test_single();
      doReset();
      rsp_ready = 1'b1;
      req_valid = 4'b0010;
      req_data[15:8] = 8'h05;
      #1;
      assertCount++;
      if (req_ready !== 4'b0010) begin failCount++; $display("[TB] FAIL single_req_ready: got %b expected 0010", req_ready); end
      @(negedge clk);
      req_valid = '0;
      #1;
      assertCount++;
      if (rsp_valid !== 1'b1 || rsp_data !== 8'hFB || rsp_id !== 2'd1) begin
         failCount++;
         $display("[TB] FAIL single_result: got v=%b d=%h id=%0d expected v=1 d=FB id=1", rsp_valid, rsp_data, rsp_id);
      end
      @(negedge clk);
      #1;
      assertCount++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0) begin failCount++; $display("[TB] FAIL single_drain: got v=%b busy=%b expected 0 0", rsp_valid, busy); end
   endtask

   task automatic test_round_robin();
      logic [W-1:0] expData [N];
      expData = '{8'hEF, 8'hDE, 8'hCD, 8'hBC};
      doReset();
      rsp_ready = 1'b1;
      req_valid = 4'b1111;
      for (int i = 0; i < N; i++) req_data[i*W +: W] = 8'(8'h11 * (i + 1));
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         #1;
         assertCount++;
         if (rsp_valid !== 1'b1 || rsp_id !== 2'(k % N) || rsp_data !== expData[k % N]) begin
            failCount++;
            $display("[TB] FAIL rr_step%0d: got v=%b id=%0d d=%h expected v=1 id=%0d d=%h", k, rsp_valid, rsp_id, rsp_data, k % N, expData[k % N]);
         end
      end
      req_valid = '0;
   endtask

   task automatic test_backpressure();
      doReset();
      rsp_ready = 1'b0;
      req_valid = 4'b0001;
      req_data[7:0] = 8'h10;
      @(negedge clk);
      req_valid = 4'b0100;
      req_data[23:16] = 8'h33;
      for (int k = 0; k < 3; k++) begin
         #1;
         assertCount++;
         if (req_ready !== 4'b0000 || rsp_valid !== 1'b1 || rsp_data !== 8'hF0 || rsp_id !== 2'd0) begin
            failCount++;
            $display("[TB] FAIL bp_hold%0d: got rdy=%b v=%b d=%h id=%0d expected rdy=0000 v=1 d=F0 id=0", k, req_ready, rsp_valid, rsp_data, rsp_id);
         end
         @(negedge clk);
      end
      rsp_ready = 1'b1;
      #1;
      assertCount++;
      if (req_ready !== 4'b0100) begin failCount++; $display("[TB] FAIL bp_release_ready: got %b expected 0100", req_ready); end
      @(negedge clk);
      req_valid = '0;
      #1;
      assertCount++;
      if (rsp_valid !== 1'b1 || rsp_data !== 8'hCD || rsp_id !== 2'd2) begin
         failCount++;
         $display("[TB] FAIL bp_next: got v=%b d=%h id=%0d expected v=1 d=CD id=2", rsp_valid, rsp_data, rsp_id);
      end
      @(negedge clk);
      #1;
      assertCount++;
      if (rsp_valid !== 1'b0) begin failCount++; $display("[TB] FAIL bp_drain: got %b expected 0", rsp_valid); end
   endtask

   task automatic test_boundaries();
      logic [W-1:0] ops [4];
      logic [W-1:0] res [4];
      logic         ovf [4];
      ops = '{8'h00, 8'h01, 8'h80, 8'h7F};
      res = '{8'h00, 8'hFF, 8'h80, 8'h81};
      ovf = '{1'b0, 1'b0, 1'b1, 1'b0};
      doReset();
      rsp_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         req_valid = 4'b0001;
         req_data[7:0] = ops[k];
         @(negedge clk);
         #1;
         assertCount++;
         if (rsp_valid !== 1'b1 || rsp_data !== res[k]) begin
            failCount++;
            $display("[TB] FAIL bound_%h: got v=%b d=%h expected v=1 d=%h", ops[k], rsp_valid, rsp_data, res[k]);
         end
`ifdef NEGATE_ARB_OVF_FLAG_EN
         assertCount++;
         if (rsp_ovf !== ovf[k]) begin failCount++; $display("[TB] FAIL ovf_%h: got %b expected %b", ops[k], rsp_ovf, ovf[k]); end
`else
         if (ovf[k] && res[k] !== ops[k]) $display("[TB] note: overflow operand table inconsistent");
`endif
      end
      req_valid = '0;
   endtask

   task automatic test_fairness_wrap();
      doReset();
      rsp_ready = 1'b1;
      req_valid = 4'b1000;
      req_data[31:24] = 8'h01;
      #1;
      assertCount++;
      if (req_ready !== 4'b1000) begin failCount++; $display("[TB] FAIL wrap_first_ready: got %b expected 1000", req_ready); end
      @(negedge clk);
      req_valid = 4'b1001;
      req_data[7:0] = 8'h02;
      req_data[31:24] = 8'h03;
      #1;
      assertCount++;
      if (rsp_id !== 2'd3 || rsp_data !== 8'hFF || req_ready !== 4'b0001) begin
         failCount++;
         $display("[TB] FAIL wrap_to0: got id=%0d d=%h rdy=%b expected id=3 d=FF rdy=0001", rsp_id, rsp_data, req_ready);
      end
      @(negedge clk);
      #1;
      assertCount++;
      if (rsp_id !== 2'd0 || rsp_data !== 8'hFE || req_ready !== 4'b1000) begin
         failCount++;
         $display("[TB] FAIL wrap_then3: got id=%0d d=%h rdy=%b expected id=0 d=FE rdy=1000", rsp_id, rsp_data, req_ready);
      end
      @(negedge clk);
      req_valid = '0;
      #1;
      assertCount++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_data !== 8'hFD) begin
         failCount++;
         $display("[TB] FAIL wrap_last: got v=%b id=%0d d=%h expected v=1 id=3 d=FD", rsp_valid, rsp_id, rsp_data);
      end
   endtask

   // Randomized traffic with random backpressure, checked cycle by cycle against the model.
   task automatic test_random();
      int           expPtr;
      logic         expValid;
      logic [W-1:0] expData;
      logic [1:0]   expId;
      logic         expOvf;
      logic [N-1:0] expReady;
      logic         canAcc;
      int           g;
      doReset();
      expPtr = 0;
      expValid = 1'b0;
      expData = '0;
      expId = '0;
      expOvf = 1'b0;
      for (int c = 0; c < 400; c++) begin
         req_valid = N'($urandom_range(0, (1 << N) - 1));
         req_data = $urandom();
         rsp_ready = ($urandom_range(0, 3) != 0);
         #1;
         g = pickReq(req_valid, expPtr);
         canAcc = !expValid || rsp_ready;
         expReady = (g >= 0 && canAcc) ? (4'b0001 << g) : 4'b0000;
         assertCount++;
         if (req_ready !== expReady || rsp_valid !== expValid || busy !== (expValid || (|req_valid))) begin
            failCount++;
            $display("[TB] FAIL rand_ctrl c=%0d: got rdy=%b v=%b busy=%b expected rdy=%b v=%b busy=%b",
                     c, req_ready, rsp_valid, busy, expReady, expValid, expValid || (|req_valid));
         end
         if (expValid) begin
            assertCount++;
            if (rsp_data !== expData || rsp_id !== expId) begin
               failCount++;
               $display("[TB] FAIL rand_data c=%0d: got d=%h id=%0d expected d=%h id=%0d", c, rsp_data, rsp_id, expData, expId);
            end
`ifdef NEGATE_ARB_OVF_FLAG_EN
            assertCount++;
            if (rsp_ovf !== expOvf) begin failCount++; $display("[TB] FAIL rand_ovf c=%0d: got %b expected %b", c, rsp_ovf, expOvf); end
`endif
         end
         if (g >= 0 && canAcc) begin
            expValid = 1'b1;
            expData = refNeg(req_data[g*W +: W]);
            expOvf = (req_data[g*W +: W] == 8'h80);
            expId = g[1:0];
            expPtr = (g + 1) % N;
         end else if (rsp_ready) begin
            expValid = 1'b0;
         end
         @(negedge clk);
      end
      req_valid = '0;
      rsp_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_backpressure();
      test_boundaries();
      test_fairness_wrap();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
